// File: rtl/cnn_stream_pkg.sv
// Shared types and sizing helpers for the CNN input streaming blocks.
package cnn_stream_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FULL, STREAM} tx_state_t;

  // Address width for a square image of the given side length.
  function automatic int unsigned addr_w(input int unsigned image_width);
    return (image_width * image_width > 1) ? $clog2(image_width * image_width) : 1;
  endfunction

  // Width of the pacing counter, which holds values up to cycles_per_pixel-1.
  function automatic int unsigned pace_w(input int unsigned cycles_per_pixel);
    return (cycles_per_pixel > 1) ? $clog2(cycles_per_pixel) : 1;
  endfunction

endpackage

// File: rtl/frame_buffer_bank.sv
// Single-port-write / single-port-read frame store with a registered read port.
module frame_buffer_bank #(
  parameter int unsigned BitSize = 32,
  parameter int unsigned Depth   = 64,
  localparam int unsigned AddrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic               clk,
  input  logic               res,
  input  logic               wr_en,
  input  logic [AddrW-1:0]   wr_addr,
  input  logic [BitSize-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AddrW-1:0]   rd_addr,
  output logic [BitSize-1:0] rd_data
);

  logic [BitSize-1:0] mem [Depth];
  logic [BitSize-1:0] rd_data_q;

  // Storage array: written on wr_en, never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register: loads on rd_en and otherwise holds the last pixel read.
  always_ff @(posedge clk) begin
    if (res) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/image_stream_tx.sv
// Frame buffer plus paced streamer feeding the first conv/pooling layer.
// Optional macro IMAGE_STREAM_TX_PINGPONG_EN adds a second bank so the next
// frame can be loaded while the current one streams.
module image_stream_tx
  import cnn_stream_pkg::*;
#(
  parameter int unsigned BitSize        = 32,
  parameter int unsigned ImageWidth     = 8,
  parameter int unsigned CyclesPerPixel = 1
) (
  input  logic               clk,
  input  logic               res,
  input  logic               wr_valid,
  input  logic [BitSize-1:0] wr_data,
  output logic               wr_ready,
  input  logic               start,
  input  logic               rx_ready,
  output logic               out_valid,
  output logic [BitSize-1:0] out_data,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned FrameSize = ImageWidth * ImageWidth;
  localparam int unsigned AW        = addr_w(ImageWidth);
  localparam int unsigned PW        = pace_w(CyclesPerPixel);
  localparam logic [AW-1:0] LastAddr = AW'(FrameSize - 1);
  localparam logic [PW-1:0] PaceLoad = PW'(CyclesPerPixel - 1);

  tx_state_t     state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [PW-1:0] pace_q, pace_d;
  logic          out_valid_q, frame_done_q;
  logic          wr_fire, last_wr, issue, last_rd;

  assign wr_fire = wr_valid && wr_ready;
  assign last_wr = wr_fire && (wr_addr_q == LastAddr);
  assign issue   = (state_q == STREAM) && (pace_q == '0) && rx_ready;
  assign last_rd = issue && (rd_addr_q == LastAddr);

  // Address and pacing counters.
  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    pace_d    = pace_q;
    if (wr_fire) wr_addr_d = last_wr ? '0 : wr_addr_q + 1'b1;
    if (issue)   rd_addr_d = last_rd ? '0 : rd_addr_q + 1'b1;
    if (issue) begin
      pace_d = PaceLoad;
    end else if (pace_q != '0) begin
      pace_d = pace_q - 1'b1;
    end
  end

`ifdef IMAGE_STREAM_TX_PINGPONG_EN
  // Banks fill and stream in strict alternation, so rd_bank always names the
  // oldest full bank.
  logic [1:0]         full_q, full_d;
  logic               fill_bank_q, fill_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic               out_bank_q;
  logic [BitSize-1:0] bank_rd [2];

  assign wr_ready = !full_q[fill_bank_q];

  // Bank bookkeeping and FSM next state.
  always_comb begin
    full_d      = full_q;
    fill_bank_d = fill_bank_q;
    rd_bank_d   = rd_bank_q;
    state_d     = state_q;
    if (last_wr) begin
      full_d[fill_bank_q] = 1'b1;
      fill_bank_d         = !fill_bank_q;
    end
    if (last_rd) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
    unique case (state_q)
      IDLE:   if (wr_fire) state_d = last_wr ? FULL : LOAD;
      LOAD:   if (last_wr) state_d = FULL;
      FULL:   if (start) state_d = STREAM;
      STREAM: begin
        if (last_rd) begin
          if (full_d[!rd_bank_q])   state_d = FULL;
          else if (wr_addr_d != '0) state_d = LOAD;
          else                      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bank bookkeeping registers; out_bank tracks which bank drives out_data.
  always_ff @(posedge clk) begin
    if (res) begin
      full_q      <= '0;
      fill_bank_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      out_bank_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      fill_bank_q <= fill_bank_d;
      rd_bank_q   <= rd_bank_d;
      if (issue) out_bank_q <= rd_bank_q;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_buffer_bank #(
      .BitSize(BitSize),
      .Depth  (FrameSize)
    ) u_bank (
      .clk    (clk),
      .res    (res),
      .wr_en  (wr_fire && (int'(fill_bank_q) == b)),
      .wr_addr(wr_addr_q),
      .wr_data(wr_data),
      .rd_en  (issue && (int'(rd_bank_q) == b)),
      .rd_addr(rd_addr_q),
      .rd_data(bank_rd[b])
    );
  end

  assign out_data = bank_rd[out_bank_q];
`else
  assign wr_ready = (state_q == IDLE) || (state_q == LOAD);

  // FSM next state for the single-bank build.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wr_fire) state_d = last_wr ? FULL : LOAD;
      LOAD:    if (last_wr) state_d = FULL;
      FULL:    if (start) state_d = STREAM;
      STREAM:  if (last_rd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  frame_buffer_bank #(
    .BitSize(BitSize),
    .Depth  (FrameSize)
  ) u_bank (
    .clk    (clk),
    .res    (res),
    .wr_en  (wr_fire),
    .wr_addr(wr_addr_q),
    .wr_data(wr_data),
    .rd_en  (issue),
    .rd_addr(rd_addr_q),
    .rd_data(out_data)
  );
`endif

  // Core state: FSM, counters and registered stream strobes.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pace_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      pace_q       <= pace_d;
      out_valid_q  <= issue;
      frame_done_q <= last_rd;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == STREAM);

endmodule
